// File: rtl/priority_resolver_irr_if.sv
// Bus between the priority resolver and the in-service register block of the 8259A.
// The resolver is the master: it drives the acknowledge strobes and the priority pointer.
interface priority_resolver_irr_if;
  logic [7:0] isrRegValue;
  logic       eoiStrobe;
  logic [2:0] resetedIndex;
  logic [2:0] toSet;
  logic [2:0] zeroLevelIndex;
  logic       readPriority;
  logic       sendVector;
  logic       secondACK;

  modport master (
    input  isrRegValue, eoiStrobe, resetedIndex,
    output toSet, zeroLevelIndex, readPriority, sendVector, secondACK
  );

  modport slave (
    output isrRegValue, eoiStrobe, resetedIndex,
    input  toSet, zeroLevelIndex, readPriority, sendVector, secondACK
  );
endinterface

// File: rtl/priority_resolver_irr.sv
// 8259A interrupt request register, priority resolver and INTA sequencer.
// Owns the rotating-priority pointer and feeds the in-service register over isr_bus.
module priority_resolver_irr #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SPURIOUS_INDEX = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic [7:0] ocw2,
  input  logic       ocw2Write,
  output logic       intOut,
  output logic [7:0] irrValue,
  priority_resolver_irr_if.master isr_bus
);

  typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

  state_e     state_q, state_d;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] edge_q, edge_d;
  logic       inta_prev_q, inta_prev_d;
  logic       int_q, int_d;
  logic [2:0] to_set_q, to_set_d;
  logic [2:0] zli_q, zli_d;
  logic       rp_q, rp_d;
  logic       sv_q, sv_d;
  logic       sa_q, sa_d;
  logic       spur_q, spur_d;
  logic       pending_q, pending_d;
  logic       aeoi_q, aeoi_d;

  logic [7:0] ir_s;
  logic [7:0] irr;
  logic [7:0] cand;
  logic [2:0] cand_pos;
  logic [2:0] isr_pos;
  logic [2:0] winner;
  logic       req_valid;
  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] ack_clear;
  logic       aeoi_fire;
  logic       unused_ocw2;

  // Position of the first set bit, scanning upward from bit 0.
  function automatic logic [2:0] first_pos(input logic [7:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) p = 3'(i);
    end
    return p;
  endfunction

  // Rotate so that bit s of v lands on bit 0.
  function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] d;
    d = {v, v} >> s;
    return d[7:0];
  endfunction

  assign unused_ocw2 = ^ocw2[4:3];

  always_comb begin
    sync_d[0] = ir;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign ir_s      = sync_q[SYNC_STAGES-1];
  assign irr       = ltim ? ir_s : edge_q;
  assign cand      = irr & ~imr;
  assign cand_pos  = first_pos(rot_right(cand, zli_q));
  assign isr_pos   = first_pos(rot_right(isr_bus.isrRegValue, zli_q));
  assign winner    = zli_q + cand_pos;
  // Equal position means the request is already in service at that level.
  assign req_valid = (|cand) && ((~|isr_bus.isrRegValue) || (cand_pos < isr_pos));
  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  always_comb begin
    state_d     = state_q;
    to_set_d    = to_set_q;
    spur_d      = spur_q;
    rp_d        = 1'b0;
    sv_d        = 1'b0;
    sa_d        = 1'b0;
    ack_clear   = 8'h00;
    aeoi_fire   = 1'b0;
    inta_prev_d = inta_n;
    ir_prev_d   = ir_s;

    unique case (state_q)
      StIdle: begin
        if (inta_fall) begin
          state_d = StAck1;
          if (req_valid) begin
            to_set_d          = winner;
            ack_clear[winner] = 1'b1;
            rp_d              = 1'b1;
            spur_d            = 1'b0;
          end else begin
            to_set_d = 3'(SPURIOUS_INDEX);
            spur_d   = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_rise) state_d = StWait2;
      end
      StWait2: begin
        if (inta_fall) begin
          state_d = StAck2;
          sv_d    = 1'b1;
        end
      end
      StAck2: begin
        if (inta_rise) begin
          state_d   = StIdle;
          sa_d      = 1'b1;
          aeoi_fire = aeoi_q & ~spur_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Edge latch drops on withdrawal (irS low) or on acknowledge.
    edge_d = (edge_q | (ir_s & ~ir_prev_q)) & ir_s & ~ack_clear;
    int_d  = (state_q == StIdle) && req_valid && !inta_fall;
  end

  always_comb begin
    zli_d     = zli_q;
    pending_d = pending_q;
    aeoi_d    = aeoi_q;

    if (isr_bus.eoiStrobe && pending_q) begin
      zli_d     = isr_bus.resetedIndex + 3'd1;
      pending_d = 1'b0;
    end
    if (aeoi_fire) begin
      zli_d = to_set_q + 3'd1;
    end
    // Applied last so an explicit priority write overrides a coincident EOI rotate.
    if (ocw2Write) begin
      case (ocw2[7:5])
        3'b111, 3'b110: zli_d     = ocw2[2:0] + 3'd1;
        3'b101:         pending_d = 1'b1;
        3'b100:         aeoi_d    = 1'b1;
        3'b000:         aeoi_d    = 1'b0;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= 8'h00;
      end
      state_q     <= StIdle;
      ir_prev_q   <= 8'h00;
      edge_q      <= 8'h00;
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      to_set_q    <= 3'd0;
      zli_q       <= 3'd0;
      rp_q        <= 1'b0;
      sv_q        <= 1'b0;
      sa_q        <= 1'b0;
      spur_q      <= 1'b0;
      pending_q   <= 1'b0;
      aeoi_q      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q     <= state_d;
      ir_prev_q   <= ir_prev_d;
      edge_q      <= edge_d;
      inta_prev_q <= inta_prev_d;
      int_q       <= int_d;
      to_set_q    <= to_set_d;
      zli_q       <= zli_d;
      rp_q        <= rp_d;
      sv_q        <= sv_d;
      sa_q        <= sa_d;
      spur_q      <= spur_d;
      pending_q   <= pending_d;
      aeoi_q      <= aeoi_d;
    end
  end

  assign intOut                 = int_q;
  assign irrValue               = irr;
  assign isr_bus.toSet          = to_set_q;
  assign isr_bus.zeroLevelIndex = zli_q;
  assign isr_bus.readPriority   = rp_q;
  assign isr_bus.sendVector     = sv_q;
  assign isr_bus.secondACK      = sa_q;

endmodule

// File: tb/tb_priority_resolver_irr.sv
// Directed bench for priority_resolver_irr: edge/level requests, ISR priority, masking,
// spurious INTA, rotation commands and reset during an INTA sequence.
module tb_priority_resolver_irr;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ir;
  logic       ltim;
  logic [7:0] imr;
  logic       inta_n;
  logic [7:0] ocw2;
  logic       ocw2Write;
  logic       intOut;
  logic [7:0] irrValue;

  int checks   = 0;
  int failures = 0;

  priority_resolver_irr_if bus ();

  priority_resolver_irr #(
    .SYNC_STAGES   (2),
    .SPURIOUS_INDEX(7)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ir       (ir),
    .ltim     (ltim),
    .imr      (imr),
    .inta_n   (inta_n),
    .ocw2     (ocw2),
    .ocw2Write(ocw2Write),
    .intOut   (intOut),
    .irrValue (irrValue),
    .isr_bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_ocw2(input logic [7:0] v);
    ocw2      = v;
    ocw2Write = 1'b1;
    step(1);
    ocw2Write = 1'b0;
  endtask

  initial begin
    reset_n              = 1'b0;
    ir                   = 8'h00;
    ltim                 = 1'b0;
    imr                  = 8'h00;
    inta_n               = 1'b1;
    ocw2                 = 8'h00;
    ocw2Write            = 1'b0;
    bus.isrRegValue      = 8'h00;
    bus.eoiStrobe        = 1'b0;
    bus.resetedIndex     = 3'd0;

    step(2);
    chk("rst_int", 8'(intOut), 8'h00);
    chk("rst_toset", 8'(bus.toSet), 8'h00);
    chk("rst_zli", 8'(bus.zeroLevelIndex), 8'h00);
    chk("rst_irr", irrValue, 8'h00);
    chk("rst_rp", 8'(bus.readPriority), 8'h00);
    reset_n = 1'b1;
    step(1);

    // Edge mode: IR3 then IR5
    ir = 8'h08;
    step(1);
    ir = 8'h28;
    step(3);
    chk("e_int_rise", 8'(intOut), 8'h01);
    chk("e_irr_both", irrValue, 8'h28);
    inta_n = 1'b0;
    step(1);
    chk("e_rp", 8'(bus.readPriority), 8'h01);
    chk("e_toset", 8'(bus.toSet), 8'h03);
    chk("e_irr_after", irrValue, 8'h20);
    chk("e_int_drop", 8'(intOut), 8'h00);
    step(1);
    chk("e_rp_width", 8'(bus.readPriority), 8'h00);
    inta_n = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    chk("e_sv", 8'(bus.sendVector), 8'h01);
    chk("e_sa_early", 8'(bus.secondACK), 8'h00);
    inta_n = 1'b1;
    step(1);
    chk("e_sa", 8'(bus.secondACK), 8'h01);
    step(1);
    chk("e_int_ir5", 8'(intOut), 8'h01);
    ir = 8'h00;
    step(4);
    chk("e_irr_clear", irrValue, 8'h00);
    chk("e_int_clear", 8'(intOut), 8'h00);

    // Priority against in-service level 2
    bus.isrRegValue = 8'h04;
    ir = 8'h20;
    step(5);
    chk("isr_low_int", 8'(intOut), 8'h00);
    chk("isr_low_irr", irrValue, 8'h20);
    ir = 8'h22;
    step(4);
    chk("isr_high_int", 8'(intOut), 8'h01);
    ir = 8'h00;
    bus.isrRegValue = 8'h00;
    step(5);
    chk("isr_idle_int", 8'(intOut), 8'h00);

    // Masking, withdrawal, spurious INTA
    imr = 8'h08;
    ir  = 8'h08;
    step(5);
    chk("mask_int", 8'(intOut), 8'h00);
    chk("mask_irr", irrValue, 8'h08);
    imr = 8'h00;
    step(1);
    chk("unmask_int", 8'(intOut), 8'h01);
    ir = 8'h00;
    step(5);
    chk("withdraw_int", 8'(intOut), 8'h00);
    chk("withdraw_irr", irrValue, 8'h00);
    inta_n = 1'b0;
    step(1);
    chk("spur_toset", 8'(bus.toSet), 8'h07);
    chk("spur_rp", 8'(bus.readPriority), 8'h00);
    inta_n = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    chk("spur_sv", 8'(bus.sendVector), 8'h01);
    inta_n = 1'b1;
    step(1);
    chk("spur_sa", 8'(bus.secondACK), 8'h01);

    // Rotation commands
    wr_ocw2(8'hC4);
    chk("setpri_zli", 8'(bus.zeroLevelIndex), 8'h05);
    wr_ocw2(8'hA0);
    chk("nseoi_hold", 8'(bus.zeroLevelIndex), 8'h05);
    bus.eoiStrobe    = 1'b1;
    bus.resetedIndex = 3'd7;
    step(1);
    bus.eoiStrobe = 1'b0;
    chk("nseoi_wrap", 8'(bus.zeroLevelIndex), 8'h00);
    bus.eoiStrobe    = 1'b1;
    bus.resetedIndex = 3'd3;
    step(1);
    bus.eoiStrobe = 1'b0;
    chk("eoi_ignored", 8'(bus.zeroLevelIndex), 8'h00);
    wr_ocw2(8'hA0);
    ocw2             = 8'hE5;
    ocw2Write        = 1'b1;
    bus.eoiStrobe    = 1'b1;
    bus.resetedIndex = 3'd1;
    step(1);
    ocw2Write     = 1'b0;
    bus.eoiStrobe = 1'b0;
    chk("collide_zli", 8'(bus.zeroLevelIndex), 8'h06);
    bus.eoiStrobe    = 1'b1;
    bus.resetedIndex = 3'd2;
    step(1);
    bus.eoiStrobe = 1'b0;
    chk("collide_pend_clr", 8'(bus.zeroLevelIndex), 8'h06);
    wr_ocw2(8'hC7);
    chk("setpri_wrap", 8'(bus.zeroLevelIndex), 8'h00);

    // Automatic EOI rotation on IR2
    wr_ocw2(8'h80);
    ir = 8'h04;
    step(4);
    chk("aeoi_int", 8'(intOut), 8'h01);
    inta_n = 1'b0;
    step(1);
    chk("aeoi_toset", 8'(bus.toSet), 8'h02);
    inta_n = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    chk("aeoi_zli_pre", 8'(bus.zeroLevelIndex), 8'h00);
    inta_n = 1'b1;
    step(1);
    chk("aeoi_sa", 8'(bus.secondACK), 8'h01);
    chk("aeoi_zli", 8'(bus.zeroLevelIndex), 8'h03);
    ir = 8'h00;
    wr_ocw2(8'h00);
    wr_ocw2(8'hC7);
    chk("aeoi_restore", 8'(bus.zeroLevelIndex), 8'h00);
    step(3);

    // Level mode on IR6
    ltim = 1'b1;
    ir   = 8'h40;
    step(4);
    chk("lvl_int", 8'(intOut), 8'h01);
    chk("lvl_irr", irrValue, 8'h40);
    inta_n = 1'b0;
    step(1);
    chk("lvl_toset", 8'(bus.toSet), 8'h06);
    chk("lvl_rp", 8'(bus.readPriority), 8'h01);
    chk("lvl_irr_reassert", irrValue, 8'h40);
    bus.isrRegValue = 8'h40;
    inta_n = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    inta_n = 1'b1;
    step(3);
    chk("lvl_same_level", 8'(intOut), 8'h00);
    chk("lvl_no_aeoi", 8'(bus.zeroLevelIndex), 8'h00);
    bus.isrRegValue = 8'h00;
    step(1);
    chk("lvl_isr_clear", 8'(intOut), 8'h01);
    ir   = 8'h00;
    ltim = 1'b0;
    step(4);
    chk("lvl_release", 8'(intOut), 8'h00);

    // Reset while in WAIT2
    ir = 8'h02;
    step(4);
    chk("wr_int", 8'(intOut), 8'h01);
    inta_n = 1'b0;
    step(1);
    chk("wr_toset", 8'(bus.toSet), 8'h01);
    inta_n = 1'b1;
    step(1);
    reset_n = 1'b0;
    ir      = 8'h00;
    #1;
    chk("wr_rst_toset", 8'(bus.toSet), 8'h00);
    chk("wr_rst_int", 8'(intOut), 8'h00);
    chk("wr_rst_irr", irrValue, 8'h00);
    chk("wr_rst_pulses", {5'b0, bus.readPriority, bus.sendVector, bus.secondACK}, 8'h00);
    step(1);
    reset_n = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(1);
    chk("wr_first_toset", 8'(bus.toSet), 8'h07);
    chk("wr_first_sv", 8'(bus.sendVector), 8'h00);
    inta_n = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    chk("wr_second_sv", 8'(bus.sendVector), 8'h01);
    inta_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_resolver_irr.md
Name: priority_resolver_irr

Overview:
Upstream neighbour of the in-service register in the 8259A PIC.
- Holds the Interrupt Request Register (IRR) and applies the mask register (IMR).
- Resolves the highest-priority pending request against the current in-service value, raises INT and sequences the two-pulse INTA cycle.
- Drives the ISR with toSet, zeroLevelIndex, readPriority, sendVector and secondACK, and owns the rotating-priority pointer.

Parameters:
SYNC_STAGES, 2, synchronizer depth on ir inputs (legal 1..3)
SPURIOUS_INDEX, 7, index reported on toSet when no request survives to the first INTA

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
ir  in  8  raw interrupt request lines IR0..IR7
ltim  in  1  ICW1 LTIM: 1 = level triggered, 0 = edge triggered
imr  in  8  OCW1 mask, 1 = masked
isrRegValue  in  8  current in-service register from ISR
inta_n  in  1  CPU acknowledge, active low, synchronous to clk
ocw2  in  8  Operation Command Word 2
ocw2Write  in  1  one-cycle strobe, ocw2 valid
eoiStrobe  in  1  one-cycle strobe from ISR, an EOI cleared resetedIndex
resetedIndex  in  3  index cleared by last EOI
intOut  out  1  INT to CPU
toSet  out  3  index being acknowledged
zeroLevelIndex  out  3  current highest-priority level
readPriority  out  1  one-cycle pulse
sendVector  out  1  one-cycle pulse
secondACK  out  1  one-cycle pulse
irrValue  out  8  current IRR contents

Behaviour:
- Reset (async, reset_n=0): IRR, synchronizers, edge latches = 0; intOut=0; toSet=0; zeroLevelIndex=0 (IR0 highest); all pulses=0; FSM=IDLE; pendingRotate=0; aeoiRotate=0. Any INTA cycle in progress is abandoned.
- Input conditioning: ir passes through SYNC_STAGES flops to give irS.
- Edge mode (ltim=0): IRR bit sets on a 0->1 transition of irS. It clears when irS returns to 0 before acknowledge (request withdrawn), or when the bit is acknowledged.
- Level mode (ltim=1): IRR bit = irS, with no latch.
- Resolution: cand = IRR & ~imr.
  - Scan circularly from zeroLevelIndex (zeroLevelIndex, +1, ... wrap 7->0). First set bit = winner.
  - Scan isrRegValue the same way. First set bit = isrTop.
  - Request is valid if cand!=0 and (isrRegValue==0 or winner's scan position < isrTop's position). Equal position is not valid.
- intOut: registered. It is 1 the cycle after a request becomes valid while FSM=IDLE. It drops the cycle after the first inta_n falling edge, and also drops if the request becomes invalid before acknowledge.
- INTA FSM. A falling edge is inta_n sampled 1 then 0; a rising edge is 0 then 1.
  - IDLE -> ACK1 on falling edge.
    - If the request is valid: toSet <= winner, clear that IRR bit/edge latch, pulse readPriority.
    - If not valid (spurious): toSet <= SPURIOUS_INDEX, no IRR change, no readPriority.
  - ACK1 -> WAIT2 on rising edge.
  - WAIT2 -> ACK2 on falling edge; pulse sendVector.
  - ACK2 -> IDLE on rising edge; pulse secondACK.
  - A falling edge in IDLE while intOut=0 is still handled as spurious.
- toSet holds its value until the next first-INTA.
- Pulses are exactly 1 clk wide and registered. An IR edge arriving during the sequence is latched normally.
- Rotation (ocw2Write, decoded on ocw2[7:5]):
  - 111 (rotate on specific EOI): zeroLevelIndex <= ocw2[2:0]+1.
  - 110 (set priority): zeroLevelIndex <= ocw2[2:0]+1.
  - 101 (rotate on non-specific EOI): pendingRotate <= 1. The next eoiStrobe sets zeroLevelIndex <= resetedIndex+1 and clears pendingRotate.
  - 100: aeoiRotate <= 1.
  - 000: aeoiRotate <= 0.
  - Other codes: no effect here.
- With aeoiRotate=1, the secondACK pulse also sets zeroLevelIndex <= toSet+1. This does not apply after a spurious sequence.
- All +1 arithmetic is 3-bit modulo (7+1=0).
- Simultaneous events:
  - ocw2Write 111/110 in the same cycle as eoiStrobe with pendingRotate: ocw2Write wins and pendingRotate clears.
  - eoiStrobe without pendingRotate is ignored.
  - imr change mid-sequence does not alter a toSet already latched.

Test Plan:
- Edge mode, zeroLevelIndex=0, pulse ir[3] then ir[5] high.
  - intOut=1 within SYNC_STAGES+2 clk.
  - INTA pair gives toSet=3, readPriority at INTA1 and IRR=0x20 after it, sendVector at INTA2, secondACK at INTA2 rising edge.
- Priority vs ISR: isrRegValue=0x04, IRR request on bit 5 -> intOut stays 0. Request on bit 1 -> intOut=1.
- Masking and withdrawal:
  - imr=0x08 with ir[3] high -> intOut=0.
  - Edge mode, ir[3] dropped before INTA -> intOut returns 0; a late INTA gives toSet=7 and no readPriority pulse.
- Rotation:
  - ocw2=0xC4 (set priority, level 4) -> zeroLevelIndex=5.
  - ocw2=0xA0, then eoiStrobe with resetedIndex=7 -> zeroLevelIndex=0.
  - With ocw2=0x80 then a full INTA on IR2 -> zeroLevelIndex=3 after secondACK.
- Level mode: ir[6] held high -> IRR bit reasserts after acknowledge. Bit 6 stays invalid while isrRegValue[6]=1.
- Assert reset_n=0 in state WAIT2 -> all outputs 0 at once. After release, the next INTA falling edge is treated as a first INTA.
